// File: rtl/pc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_pkg : shared encodings for the PC sequencer      rev 1.0      |
// +------------------------------------------------------------------+
package pc_pkg;

  localparam logic [1:0] KIND_JAL  = 2'b00;
  localparam logic [1:0] KIND_JALR = 2'b01;
  localparam logic [1:0] KIND_BR   = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TRAP = 2'd2;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_sequencer_if : fetch/redirect/trap bundle        rev 1.0      |
// +------------------------------------------------------------------+
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             fetch_ready;
  logic             redir_valid;
  logic [1:0]       redir_kind;
  logic [2:0]       cond;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic [WIDTH-1:0] src_pc;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] offset;
  logic             trap_ack;
  logic [WIDTH-1:0] instr_addr;
  logic             fetch_valid;
  logic             taken;
  logic [WIDTH-1:0] link_addr;
  logic             trap;
  logic [WIDTH-1:0] bad_addr;

  modport slave (
    input  fetch_ready, redir_valid, redir_kind, cond,
           flag_n, flag_z, flag_c, flag_v,
           src_pc, base, offset, trap_ack,
    output instr_addr, fetch_valid, taken, link_addr, trap, bad_addr
  );

  modport master (
    output fetch_ready, redir_valid, redir_kind, cond,
           flag_n, flag_z, flag_c, flag_v,
           src_pc, base, offset, trap_ack,
    input  instr_addr, fetch_valid, taken, link_addr, trap, bad_addr
  );
endinterface
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_cond : RV32I funct3 evaluation on rs1-rs2 flags  rev 1.0  |
// +------------------------------------------------------------------+
module branch_cond
  import pc_pkg::*;
(
  input  logic [2:0]  cond,
  input  alu_flags_t  flags,
  output logic        result
);

  // flags.c is a borrow, so it is set exactly when rs1 < rs2 unsigned.
  always_comb begin
    result = 1'b0;
    case (cond)
      F3_BEQ:  result = flags.z;
      F3_BNE:  result = ~flags.z;
      F3_BLT:  result = flags.n ^ flags.v;
      F3_BGE:  result = ~(flags.n ^ flags.v);
      F3_BLTU: result = flags.c;
      F3_BGEU: result = ~flags.c;
      default: result = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_sequencer : fetch address generation with redirect and trap  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h100)
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] bad_q, bad_d;

  alu_flags_t       flags;
  logic             cond_ok;
  logic             taken;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] target;
  logic             misaligned;

  assign flags = '{n: bus.flag_n, z: bus.flag_z, c: bus.flag_c, v: bus.flag_v};

  branch_cond u_branch_cond (
    .cond   (bus.cond),
    .flags  (flags),
    .result (cond_ok)
  );

  assign taken = bus.redir_valid &
                 ((bus.redir_kind == KIND_JAL) |
                  (bus.redir_kind == KIND_JALR) |
                  ((bus.redir_kind == KIND_BR) & cond_ok));

  assign jalr_sum   = bus.base + bus.offset;
  assign target     = (bus.redir_kind == KIND_JALR) ? (jalr_sum & ~WIDTH'(1))
                                                    : (bus.src_pc + bus.offset);
  assign misaligned = |target[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bad_d   = bad_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // A taken redirect wins over both stall and sequential advance.
        if (taken) begin
          if (misaligned) begin
            state_d = ST_TRAP;
            bad_d   = target;
            pc_d    = TRAP_VECTOR;
          end else begin
            pc_d = target;
          end
        end else if (bus.fetch_ready) begin
          pc_d = pc_q + WIDTH'(4);
        end
      end
      ST_TRAP: begin
        pc_d = TRAP_VECTOR;
        if (bus.trap_ack) begin
          state_d = ST_RUN;
          pc_d    = TRAP_VECTOR + WIDTH'(4);
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bad_q   <= bad_d;
    end
  end

  assign bus.instr_addr  = pc_q;
  assign bus.fetch_valid = (state_q != ST_BOOT);
  assign bus.trap        = (state_q == ST_TRAP);
  assign bus.bad_addr    = bad_q;
  assign bus.taken       = taken;
  assign bus.link_addr   = bus.src_pc + WIDTH'(4);

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, address/offset width in bits (minimum 8).
REQ-002 Parameter RESET_VECTOR, default 0, first fetch address after reset.
REQ-003 Parameter TRAP_VECTOR, default 'h100, fetch address while trapped.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset.
REQ-006 Port fetch_ready  in  1  instruction memory accepts instr_addr this cycle.
REQ-007 Port redir_valid  in  1  control-transfer request from execute.
REQ-008 Port redir_kind  in  2  00 JAL, 01 JALR, 10 conditional branch, 11 reserved.
REQ-009 Port cond  in  3  RV32I branch funct3.
REQ-010 Port flag_n, flag_z, flag_c, flag_v  in  1 each  ALU flags of rs1-rs2; flag_c = borrow.
REQ-011 Port src_pc  in  WIDTH  address of the requesting instruction.
REQ-012 Port base  in  WIDTH  rs1 value for JALR.
REQ-013 Port offset  in  WIDTH  signed immediate.
REQ-014 Port trap_ack  in  1  handler acknowledges trap.
REQ-015 Port instr_addr  out  WIDTH  registered fetch address.
REQ-016 Port fetch_valid  out  1  instr_addr is a valid request.
REQ-017 Port taken  out  1  combinational: current request redirects.
REQ-018 Port link_addr  out  WIDTH  combinational src_pc+4.
REQ-019 Port trap  out  1  registered, high while in TRAP state.
REQ-020 Port bad_addr  out  WIDTH  registered misaligned target captured on trap entry.

Function
REQ-021 States: BOOT, RUN, TRAP; one-hot or binary encoding is free.
REQ-022 BOOT lasts exactly one cycle after reset release, fetch_valid=0, then RUN.
REQ-023 RUN: fetch_valid=1; instr_addr += 4 on a cycle with fetch_ready=1 and no taken redirect; holds otherwise (stall).
REQ-024 taken = redir_valid & (kind JAL | kind JALR | (kind branch & cond true)); kind 11 never taken.
REQ-025 cond: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 C; 111 !C; 010/011 false.
REQ-026 Target: JAL/branch src_pc+offset; JALR (base+offset) with bit 0 cleared; all sums modulo 2^WIDTH.
REQ-027 Taken redirect in RUN with target[1:0]==0: instr_addr=target next cycle regardless of fetch_ready (redirect overrides stall, pending fetch dropped).
REQ-028 Taken redirect with target[1]=1 (after JALR bit-0 clear): enter TRAP, bad_addr=target, instr_addr=TRAP_VECTOR.
REQ-029 TRAP: trap=1, fetch_valid=1, instr_addr held at TRAP_VECTOR, redirects ignored; trap_ack returns to RUN with instr_addr=TRAP_VECTOR+4 next cycle.
REQ-030 redir_valid in BOOT is ignored; taken still reflects REQ-024.
REQ-031 Redirect latency one cycle: request at edge k seen on instr_addr after edge k.

Reset
REQ-032 rst asserted: instr_addr=RESET_VECTOR, fetch_valid=0, trap=0, bad_addr=0, state=BOOT, immediately and asynchronously.
REQ-033 rst asserted mid-TRAP or mid-stall discards all pending state.

Structure
REQ-034 redir_kind encodings, funct3 constants and state encoding live in shared package pc_pkg.
REQ-035 Branch-condition evaluation is sub-module branch_cond (cond, flags -> 1-bit result), purely combinational.

Verification
REQ-036 Reset release, fetch_ready=1 for 4 cycles -> instr_addr 0 (BOOT, valid=0), 0, 4, 8, 12.
REQ-037 fetch_ready=0 at instr_addr=8 for 3 cycles -> instr_addr stays 8, then 12 on ready.
REQ-038 Branch cond=000 Z=1, src_pc=8, offset=20 -> taken=1, instr_addr=28; Z=0 -> taken=0, sequential.
REQ-039 BLT cond=100 N=1 V=0, src_pc=40, offset=-16 -> instr_addr=24; N=1 V=1 -> not taken; BLTU C=1 taken.
REQ-040 JALR base=0x101, offset=2 -> target 0x102 misaligned: trap=1, bad_addr=0x102, instr_addr=0x100; trap_ack -> 0x104.
REQ-041 JAL src_pc=0xFFFFFFFC, offset=8 with fetch_ready=0 -> instr_addr=4 (wrap), link_addr=0 (wrap); rst pulse mid-TRAP -> instr_addr=0, fetch_valid=0.
